// File: rtl/virtualized_reconstruction_filter_pkg.sv
// Shared types and helpers for the time-multiplexed second-order CIC decoder.
// Holds the FSM state type, the bit-to-sample mapping and the saturating output scaler.
package virtualized_reconstruction_filter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic int acc_width_of(input int log2_decim);
    return 2 * log2_decim + 2;
  endfunction

  function automatic logic signed [63:0] full_pos(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] full_neg(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  // A 1 bit is a +1 sample, a 0 bit is a -1 sample.
  function automatic logic signed [1:0] bit_to_x(input logic b);
    return b ? 2'sb01 : 2'sb11;
  endfunction

  // +R^2 lands one LSB past full scale and clamps; -R^2 lands exactly on full_neg.
  function automatic logic signed [63:0] scale_sat(input logic signed [63:0] y,
                                                   input int shift,
                                                   input int width);
    logic signed [63:0] s;
    s = y <<< shift;
    if (s > full_pos(width)) return full_pos(width);
    if (s < full_neg(width)) return full_neg(width);
    return s;
  endfunction

endpackage

// File: rtl/virtualized_reconstruction_filter_cic2.sv
// One step of a second-order CIC for a single channel: integrators, comb and output scaling.
// Purely combinational; the caller decides which of the updated states to commit.
module cic2_channel_datapath
  import virtualized_reconstruction_filter_pkg::*;
#(
  parameter int LOG2_DECIM = 6,
  parameter int OUT_WIDTH  = 24,
  localparam int ACC_WIDTH = acc_width_of(LOG2_DECIM)
) (
  input  logic                        x_bit,
  input  logic signed [ACC_WIDTH-1:0] int1,
  input  logic signed [ACC_WIDTH-1:0] int2,
  input  logic signed [ACC_WIDTH-1:0] z1,
  input  logic signed [ACC_WIDTH-1:0] z2,
  output logic signed [ACC_WIDTH-1:0] int1_next,
  output logic signed [ACC_WIDTH-1:0] int2_next,
  output logic signed [ACC_WIDTH-1:0] z1_next,
  output logic signed [ACC_WIDTH-1:0] z2_next,
  output logic signed [OUT_WIDTH-1:0] sample
);

  localparam int SHIFT = OUT_WIDTH - 1 - 2 * LOG2_DECIM;

  logic signed [1:0]           x;
  logic signed [ACC_WIDTH-1:0] x_ext;
  logic signed [ACC_WIDTH-1:0] c1;
  logic signed [ACC_WIDTH-1:0] y;

  // All arithmetic wraps at ACC_WIDTH; the CIC relies on that modular behaviour.
  always_comb begin
    x         = bit_to_x(x_bit);
    x_ext     = {{(ACC_WIDTH-2){x[1]}}, x};
    int1_next = int1 + x_ext;
    int2_next = int2 + int1_next;
    c1        = int2_next - z1;
    y         = c1 - z2;
    z1_next   = int2_next;
    z2_next   = c1;
    sample    = OUT_WIDTH'(scale_sat({{(64-ACC_WIDTH){y[ACC_WIDTH-1]}}, y}, SHIFT, OUT_WIDTH));
  end

endmodule

// File: rtl/virtualized_reconstruction_filter.sv
// Shared CIC decimator scanning all virtualized bitstream channels once per frame.
// Owns the frame FSM, the decimation counter, per-channel state arrays and the log readback.
module virtualized_reconstruction_filter
  import virtualized_reconstruction_filter_pkg::*;
#(
  parameter int NUM_CHANNELS = 10,
  parameter int LOG2_DECIM   = 6,
  parameter int OUT_WIDTH    = 24,
  localparam int ACC_WIDTH   = acc_width_of(LOG2_DECIM),
  localparam int CH_WIDTH    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CHANNELS-1:0]     bitstream_in,
  input  logic                        bitstream_valid,
  output logic                        busy,
  output logic                        overrun,
  input  logic                        overrun_clear,
  output logic signed [OUT_WIDTH-1:0] sample_out,
  output logic [CH_WIDTH-1:0]         sample_channel,
  output logic                        sample_valid,
  input  logic [CH_WIDTH-1:0]         log_address,
  output logic signed [OUT_WIDTH-1:0] log_value
);

  localparam logic [CH_WIDTH-1:0] LAST_CH = CH_WIDTH'(NUM_CHANNELS - 1);

  state_t                      state;
  logic [NUM_CHANNELS-1:0]     shadow;
  logic [CH_WIDTH-1:0]         ch_idx;
  logic [LOG2_DECIM-1:0]       dec_cnt;
  logic                        dump_frame;

  logic signed [ACC_WIDTH-1:0] int1_mem [NUM_CHANNELS];
  logic signed [ACC_WIDTH-1:0] int2_mem [NUM_CHANNELS];
  logic signed [ACC_WIDTH-1:0] z1_mem   [NUM_CHANNELS];
  logic signed [ACC_WIDTH-1:0] z2_mem   [NUM_CHANNELS];
  logic signed [OUT_WIDTH-1:0] last_sample [NUM_CHANNELS];

  logic signed [ACC_WIDTH-1:0] int1_nx;
  logic signed [ACC_WIDTH-1:0] int2_nx;
  logic signed [ACC_WIDTH-1:0] z1_nx;
  logic signed [ACC_WIDTH-1:0] z2_nx;
  logic signed [OUT_WIDTH-1:0] dp_sample;

  assign dump_frame = (dec_cnt == '1);

  cic2_channel_datapath #(
    .LOG2_DECIM (LOG2_DECIM),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_datapath (
    .x_bit     (shadow[ch_idx]),
    .int1      (int1_mem[ch_idx]),
    .int2      (int2_mem[ch_idx]),
    .z1        (z1_mem[ch_idx]),
    .z2        (z2_mem[ch_idx]),
    .int1_next (int1_nx),
    .int2_next (int2_nx),
    .z1_next   (z1_nx),
    .z2_next   (z2_nx),
    .sample    (dp_sample)
  );

  // A strobe arriving while scanning is dropped; the drop beats a same-cycle clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      shadow         <= '0;
      ch_idx         <= '0;
      dec_cnt        <= '0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
      sample_valid   <= 1'b0;
      sample_out     <= '0;
      sample_channel <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        int1_mem[i]    <= '0;
        int2_mem[i]    <= '0;
        z1_mem[i]      <= '0;
        z2_mem[i]      <= '0;
        last_sample[i] <= '0;
      end
    end else begin
      sample_valid <= 1'b0;

      if (bitstream_valid && state == SCAN) begin
        overrun <= 1'b1;
      end else if (overrun_clear) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bitstream_valid) begin
            shadow <= bitstream_in;
            ch_idx <= '0;
            busy   <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          int1_mem[ch_idx] <= int1_nx;
          int2_mem[ch_idx] <= int2_nx;
          if (dump_frame) begin
            z1_mem[ch_idx]      <= z1_nx;
            z2_mem[ch_idx]      <= z2_nx;
            last_sample[ch_idx] <= dp_sample;
            sample_out          <= dp_sample;
            sample_channel      <= ch_idx;
            sample_valid        <= 1'b1;
          end
          if (ch_idx == LAST_CH) begin
            state   <= IDLE;
            busy    <= 1'b0;
            dec_cnt <= dec_cnt + LOG2_DECIM'(1);
          end else begin
            ch_idx <= ch_idx + CH_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered read: a write to the same channel this cycle is seen only next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      log_value <= '0;
    end else if (int'(log_address) < NUM_CHANNELS) begin
      log_value <= last_sample[log_address];
    end else begin
      log_value <= '0;
    end
  end

endmodule

// File: doc/virtualized_reconstruction_filter.md
# virtualized_reconstruction_filter

Time-multiplexed decoder for the virtualized second-order sigma-delta modulator: takes the parallel per-channel bitstream vector, and runs one shared second-order CIC decimator over all channels in turn. Each channel's integrator and comb state is kept in register arrays. The block emits 24-bit signed reconstructed samples tagged with a channel number, plus a log readback of the last sample per channel. It replaces the per-channel reconstruction filter instances on the modulator output.

## Interface
- NUM_CHANNELS, 10, number of virtualized bitstreams
- LOG2_DECIM, 6, decimation ratio R = 2^LOG2_DECIM frames
- OUT_WIDTH, 24, output sample width (signed)
- Derived: ACC_WIDTH = 2*LOG2_DECIM+2; CH_WIDTH = clog2(NUM_CHANNELS)

- clock  in  1  single clock for the whole block
- reset  in  1  asynchronous, active-high; clears all state
- bitstream_in  in  NUM_CHANNELS  one bit per channel, 1 = +1, 0 = -1
- bitstream_valid  in  1  frame strobe, one cycle per bitstream period
- busy  out  1  high while a frame is being processed
- overrun  out  1  sticky; set when a frame is dropped
- overrun_clear  in  1  clears overrun
- sample_out  out  OUT_WIDTH  reconstructed sample, signed
- sample_channel  out  CH_WIDTH  channel of sample_out
- sample_valid  out  1  one-cycle qualifier for sample_out/sample_channel
- log_address  in  CH_WIDTH  channel selected for readback
- log_value  out  OUT_WIDTH  last sample emitted for log_address, registered

## Operation
- FSM with two states, IDLE and SCAN; reset state is IDLE.
- IDLE:
  - bitstream_valid captures bitstream_in into a shadow register.
  - ch_idx <= 0, state -> SCAN.
- SCAN processes one channel per cycle, channel ch_idx, with x = +1/-1 from the shadow bit:
  - int1' = int1[ch] + x
  - int2' = int2[ch] + int1'
  - Both are written back.
- Integrators are ACC_WIDTH signed and wrap modulo 2^ACC_WIDTH. Wrap is intentional and required for CIC correctness.
- dec_cnt is a shared LOG2_DECIM-bit frame counter. When dec_cnt == R-1 (dump frame), each channel also runs the comb:
  - c1 = int2' - z1[ch]; z1[ch] <= int2'
  - y = c1 - z2[ch]; z2[ch] <= c1
  - Comb arithmetic is ACC_WIDTH wrapping.
- Output scaling: sample = y << (OUT_WIDTH-1-2*LOG2_DECIM).
  - y = +R^2 saturates to full_pos (0x7FFFFF).
  - y = -R^2 maps exactly to full_neg (0x800000).
- On a dump frame, each channel's sample is also written to last_sample[ch].
- On the last channel (ch_idx == NUM_CHANNELS-1):
  - state -> IDLE.
  - dec_cnt increments, wrapping R-1 -> 0.
- bitstream_valid while in SCAN:
  - The frame is dropped and overrun is set.
  - State is unaffected.
- overrun_clear and a simultaneous drop: the set wins.

## Timing
- Reset values:
  - busy, overrun, sample_valid = 0; sample_out, sample_channel, log_value = 0.
  - All int1/int2/z1/z2/last_sample = 0; dec_cnt = 0; state IDLE.
- Edge E0 samples bitstream_valid in IDLE.
- Channel k is processed between edges E0+k and E0+k+1.
- On a dump frame, sample_valid is high for the cycle after edge E0+k+1, with sample_channel = k.
  - This gives NUM_CHANNELS consecutive valid cycles, channels in ascending order.
- busy is registered: high from E0+1 through E0+NUM_CHANNELS, low after.
- Minimum accepted frame spacing is NUM_CHANNELS+1 cycles. A strobe on the edge that returns the block to IDLE is dropped.
- log_value reflects last_sample[log_address] one cycle after the address is applied. On a same-cycle write to that channel, the old value is returned.
- Reset asserted mid-SCAN aborts the frame immediately. No partial sample_valid follows.

## Structure
- Shared package holds:
  - full_pos and full_neg for a given width.
  - The bit to +1/-1 mapping function.
  - ACC_WIDTH derivation.
  - The saturating scale function.
  - The FSM state typedef.
- Natural sub-module: cic2_channel_datapath. It is combinational: int1/int2/z1/z2 and x in, updated state plus scaled sample out.
- The wrapper owns the FSM, dec_cnt, state arrays and output registers.

## Test plan
All scenarios use LOG2_DECIM = 6 (R = 64) and NUM_CHANNELS = 10, with frames every 20 cycles.
- **Constant all-ones on channel 7:**
  - First dump emits 0x410000 (y = 2080).
  - Second and later dumps emit 0x7FFFFF (y = 4096, saturated).
  - sample_channel = 7 in the 8th valid cycle of each burst.
- **All-zeros on channel 0:** first dump 0xBF0000, then 0x800000 steadily.
- **Alternating 1,0,1,0 on channel 2 (frame 0 = 1):** first dump 0x010000, then 0x000000 thereafter.
- **Timing checks:**
  - Frame strobe at E0 gives busy high for exactly 10 cycles.
  - On the dump frame, sample_valid is high for 10 consecutive cycles starting after E0+1, with channels 0..9 in order.
- **Overrun:**
  - A second strobe 5 cycles after the first sets overrun, and integrator state is unchanged by the dropped frame.
  - overrun_clear then clears it.
  - Simultaneous clear and drop leaves it set.
- **Reset mid-SCAN at channel 4:**
  - All outputs return to 0 and there is no further sample_valid.
  - The next all-ones run reproduces the first-dump value 0x410000.
  - log_address = 7 reads back the last emitted channel-7 sample one cycle later.
